pipe_stage_buf: RTL

Parametrised inter-stage pipeline register for the CPU pipeline. It is the successor to the fixed IF/ID/EX/MEM/WB stage registers.
- Replaces the global "stop" hold with a per-stage valid/ready handshake.
- Adds a flush input for branch and exception kill.
- Adds an optional two-entry skid buffer, so ready is registered and throughput stays 1 op/cycle under back-pressure.
- Carries an arbitrary payload plus the trace PC.

---
 rtl/pipe_stage_buf.sv | 74 +++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage register with optional two-entry skid buffer and flush
module pipe_stage_buf #(
    parameter int DATA_W = 38,
    parameter int PC_W   = 32,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
);
    logic [1:0]        occ, occ_nxt;
    logic              rdy_q;
    logic [DATA_W-1:0] m_data, s_data;
    logic [PC_W-1:0]   m_pc, s_pc;
    logic              in_fire, out_fire, load_in, load_s, load_ms;

    // handshake decode; with SKID=0 occupancy never exceeds 1, so the skid paths never fire
    always_comb begin
        out_valid = occ != 2'd0;
        in_ready  = SKID ? rdy_q : (~out_valid | out_ready);
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        occ_nxt   = flush ? 2'd0 : occ + {1'b0, in_fire} - {1'b0, out_fire};
        load_in   = ~flush & in_fire & (occ == 2'd0 | out_fire);
        load_s    = ~flush & in_fire & ~out_fire & occ == 2'd1;
        load_ms   = ~flush & out_fire & occ == 2'd2;
    end

    // occupancy and the registered ready, which deasserts only when both entries will be full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ   <= 2'd0;
            rdy_q <= 1'b1;
        end else begin
            occ   <= occ_nxt;
            rdy_q <= occ_nxt != 2'd2;
        end
    end

    // payload registers load only on transfers and otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= '0;
            m_pc   <= '0;
            s_data <= '0;
            s_pc   <= '0;
        end else begin
            if (load_in) begin
                m_data <= in_data;
                m_pc   <= in_pc;
            end else if (load_ms) begin
                m_data <= s_data;
                m_pc   <= s_pc;
            end
            if (load_s) begin
                s_data <= in_data;
                s_pc   <= in_pc;
            end
        end
    end

    assign out_data  = m_data;
    assign out_pc    = m_pc;
    assign occupancy = occ;
endmodule
